// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative M-extension divider.
//   XLEN_DEFAULT : default operand/result width
//   div_op_e     : divide op, encoded as funct3[1:0]
//   div_state_e  : divider control states
//   min_int()    : most-negative two's-complement value for a given width
package mdu_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned MAX_XLEN     = 128;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Callers truncate the result to their own width.
    function automatic logic [MAX_XLEN-1:0] min_int(input int unsigned width);
        return MAX_XLEN'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-division step on the {rem, quo} shift pair.
//   rem, quo, divisor : current partial remainder, dividend/quotient register, divisor
//   rem_next_c        : partial remainder after the shift and conditional subtract
//   quo_next_c        : quotient register after shifting in the new quotient bit
module mdu_div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next_c,
    output logic [XLEN-1:0] quo_next_c
);

    logic [XLEN:0] shifted;
    logic          ge;

    // Compare at XLEN+1 bits: the shifted remainder can exceed 2^XLEN-1.
    always_comb begin
        shifted    = {rem, quo[XLEN-1]};
        ge         = (shifted >= {1'b0, divisor});
        rem_next_c = ge ? XLEN'(shifted - {1'b0, divisor}) : shifted[XLEN-1:0];
        quo_next_c = {quo[XLEN-2:0], ge};
    end

endmodule

// File: rtl/mdu_div_iter.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU.
// BITS_PER_CYCLE must be 1 or 2 and divide XLEN.
//   clk, rst             : clock, synchronous active-high reset
//   flush                : kills any operation in flight
//   in_valid/in_ready    : operand handshake (op, a, b)
//   out_valid/out_ready  : result handshake (result)
//   stallreq             : execute-stage stall request
module mdu_div_iter
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN           = XLEN_DEFAULT,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            stallreq
);

    localparam int unsigned NSTEP = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(NSTEP + 1);
    localparam logic [XLEN-1:0] MIN_INT = XLEN'(min_int(XLEN));

    div_state_e      state, state_next;
    logic [CNT_W-1:0] cnt;
    div_op_e         op_q;
    logic [XLEN-1:0] rem_q, quo_q, divisor_q;
    logic            neg_q, neg_r;

    logic            accept, is_signed, div_by_zero, overflow, special, last_iter, rem_sel_q;
    logic [XLEN-1:0] abs_a, abs_b, special_res, calc_res;
    logic [XLEN-1:0] rem_chain [BITS_PER_CYCLE+1];
    logic [XLEN-1:0] quo_chain [BITS_PER_CYCLE+1];

    // Issue-side decode: accept, magnitudes, early-out cases.
    assign accept      = in_valid & (state == IDLE) & ~flush;
    assign is_signed   = ~op[0];
    assign div_by_zero = (b == '0);
    assign overflow    = is_signed & (a == MIN_INT) & (b == '1);
    assign special     = div_by_zero | overflow;
    assign abs_a       = (is_signed & a[XLEN-1]) ? -a : a;
    assign abs_b       = (is_signed & b[XLEN-1]) ? -b : b;
    assign special_res = div_by_zero ? (op[1] ? a : '1) : (op[1] ? '0 : MIN_INT);

    assign last_iter = (cnt == CNT_W'(1));
    assign rem_sel_q = (op_q == REM) | (op_q == REMU);
    assign stallreq  = in_valid | (state != IDLE);

    // Chain of restoring steps retiring BITS_PER_CYCLE quotient bits per cycle.
    assign rem_chain[0] = rem_q;
    assign quo_chain[0] = quo_q;
    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        mdu_div_step #(.XLEN(XLEN)) u_step (
            .rem        (rem_chain[i]),
            .quo        (quo_chain[i]),
            .divisor    (divisor_q),
            .rem_next_c (rem_chain[i+1]),
            .quo_next_c (quo_chain[i+1])
        );
    end

    // Sign fix-up applied to the final iteration's output.
    assign calc_res = rem_sel_q
                    ? (neg_r ? -rem_chain[BITS_PER_CYCLE] : rem_chain[BITS_PER_CYCLE])
                    : (neg_q ? -quo_chain[BITS_PER_CYCLE] : quo_chain[BITS_PER_CYCLE]);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and handshake decode.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) state_next = special ? DONE : CALC;
            end
            CALC: if (last_iter) state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    // Operand latches, iteration datapath and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            op_q      <= DIV;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            result    <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (accept) begin
            op_q      <= div_op_e'(op);
            rem_q     <= '0;
            quo_q     <= abs_a;
            divisor_q <= abs_b;
            neg_q     <= is_signed & (a[XLEN-1] ^ b[XLEN-1]);
            neg_r     <= is_signed & a[XLEN-1];
            cnt       <= CNT_W'(NSTEP);
            if (special) result <= special_res;
        end else if (state == CALC) begin
            rem_q <= rem_chain[BITS_PER_CYCLE];
            quo_q <= quo_chain[BITS_PER_CYCLE];
            cnt   <= cnt - CNT_W'(1);
            if (last_iter) result <= calc_res;
        end
    end

endmodule

// File: tb/tb_mdu_div_iter.sv
// Bench for mdu_div_iter: XLEN=32/BPC=1 and XLEN=64/BPC=2 instances,
// directed vector table, handshake/flush/reset sequences, random vectors.
module tb_mdu_div_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush;

    logic        v1_in_valid, v1_in_ready, v1_out_valid, v1_out_ready, v1_stallreq;
    logic [1:0]  v1_op;
    logic [31:0] v1_a, v1_b, v1_result;

    logic        v2_in_valid, v2_in_ready, v2_out_valid, v2_out_ready, v2_stallreq;
    logic [1:0]  v2_op;
    logic [63:0] v2_a, v2_b, v2_result;

    mdu_div_iter #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(v1_in_valid), .in_ready(v1_in_ready),
        .op(v1_op), .a(v1_a), .b(v1_b), .out_valid(v1_out_valid), .out_ready(v1_out_ready),
        .result(v1_result), .stallreq(v1_stallreq)
    );

    mdu_div_iter #(.XLEN(64), .BITS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(v2_in_valid), .in_ready(v2_in_ready),
        .op(v2_op), .a(v2_a), .b(v2_b), .out_valid(v2_out_valid), .out_ready(v2_out_ready),
        .result(v2_result), .stallreq(v2_stallreq)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    logic [31:0] q1[$];
    logic [63:0] q2[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : a;
        case (op)
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic logic [63:0] ref64(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        logic signed [63:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 64'h0) return op[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        if (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return op[1] ? 64'h0 : a;
        case (op)
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    // Issue one op on dut1, check latency/result, optionally hold off out_ready.
    task automatic d1_run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input int hold, input string name);
        int cyc;
        logic [31:0] expv;
        chk({name, " in_ready"}, 64'(v1_in_ready), 64'(1));
        v1_op = op; v1_a = a; v1_b = b; v1_in_valid = 1'b1;
        q1.push_back(exp);
        @(negedge clk);
        v1_in_valid = 1'b0;
        v1_op = ~op; v1_a = ~a; v1_b = b + 32'd1;
        cyc = 1;
        while (!v1_out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (!v1_out_valid) begin
            chk({name, " timeout"}, 64'(0), 64'(1));
            void'(q1.pop_front());
            return;
        end
        chk({name, " latency"}, 64'(cyc), 64'(lat));
        expv = q1.pop_front();
        chk({name, " result"}, 64'(v1_result), 64'(expv));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, " hold out_valid"}, 64'(v1_out_valid), 64'(1));
            chk({name, " hold in_ready"}, 64'(v1_in_ready), 64'(0));
            chk({name, " hold result"}, 64'(v1_result), 64'(expv));
            chk({name, " hold stallreq"}, 64'(v1_stallreq), 64'(1));
        end
        v1_out_ready = 1'b1;
        @(negedge clk);
        v1_out_ready = 1'b0;
        chk({name, " idle after pop"}, 64'({v1_in_ready, v1_out_valid}), 64'(2'b10));
    endtask

    task automatic d2_run(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int lat, input string name);
        int cyc;
        chk({name, " in_ready"}, 64'(v2_in_ready), 64'(1));
        v2_op = op; v2_a = a; v2_b = b; v2_in_valid = 1'b1;
        q2.push_back(exp);
        @(negedge clk);
        v2_in_valid = 1'b0;
        v2_a = ~a; v2_b = ~b;
        cyc = 1;
        while (!v2_out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (!v2_out_valid) begin
            chk({name, " timeout"}, 64'(0), 64'(1));
            void'(q2.pop_front());
            return;
        end
        chk({name, " latency"}, 64'(cyc), 64'(lat));
        chk({name, " result"}, v2_result, q2.pop_front());
        v2_out_ready = 1'b1;
        @(negedge clk);
        v2_out_ready = 1'b0;
        chk({name, " idle after pop"}, 64'({v2_in_ready, v2_out_valid}), 64'(2'b10));
    endtask

    initial begin
        vec_t tbl[16];
        int   n_ov;
        logic [1:0]  rop;
        logic [31:0] ra32, rb32;
        logic [63:0] ra64, rb64;
        logic        sp;

        tbl[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         33, "divu 100/7"};
        tbl[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          33, "remu 100/7"};
        tbl[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33, "div -7/2"};
        tbl[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33, "rem -7/2"};
        tbl[4]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          33, "rem 7/-2"};
        tbl[5]  = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33, "div 7/-2"};
        tbl[6]  = '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1,  "divu 5/0"};
        tbl[7]  = '{2'b10, 32'd5,          32'd0,          32'd5,          1,  "rem 5/0"};
        tbl[8]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  "div min/-1"};
        tbl[9]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  "rem min/-1"};
        tbl[10] = '{2'b01, 32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          33, "divu wide"};
        tbl[11] = '{2'b11, 32'hFFFF_FFFF,  32'h8000_0000,  32'h7FFF_FFFF,  33, "remu wide"};
        tbl[12] = '{2'b00, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2,          33, "div -8/-3"};
        tbl[13] = '{2'b10, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'hFFFF_FFFE,  33, "rem -8/-3"};
        tbl[14] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33, "divu min/max"};
        tbl[15] = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33, "remu min/max"};

        rst = 1'b1; flush = 1'b0;
        v1_in_valid = 1'b0; v1_out_ready = 1'b0; v1_op = 2'b00; v1_a = '0; v1_b = '0;
        v2_in_valid = 1'b0; v2_out_ready = 1'b0; v2_op = 2'b00; v2_a = '0; v2_b = '0;
        repeat (3) @(negedge clk);

        // Reset state, and no accept while reset is held.
        chk("rst in_ready", 64'(v1_in_ready), 64'(1));
        chk("rst out_valid", 64'(v1_out_valid), 64'(0));
        chk("rst result", 64'(v1_result), 64'(0));
        chk("rst stallreq lo", 64'(v1_stallreq), 64'(0));
        chk("rst d2 state", 64'({v2_in_ready, v2_out_valid, v2_stallreq}), 64'(3'b100));
        chk("rst d2 result", v2_result, 64'(0));
        v1_in_valid = 1'b1;
        #1;
        chk("rst stallreq hi", 64'(v1_stallreq), 64'(1));
        @(negedge clk);
        chk("rst no accept", 64'(v1_in_ready), 64'(1));
        v1_in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) d1_run(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, 0, tbl[i].name);

        // Consumer stalls for 5 cycles.
        d1_run(2'b01, 32'd100, 32'd7, 32'd14, 33, 5, "hold divu");

        // Flush in CALC cycle 10.
        v1_op = 2'b01; v1_a = 32'd1000; v1_b = 32'd3; v1_in_valid = 1'b1;
        @(negedge clk);
        v1_in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("calc stallreq", 64'(v1_stallreq), 64'(1));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush in_ready", 64'(v1_in_ready), 64'(1));
        chk("flush out_valid", 64'(v1_out_valid), 64'(0));
        chk("flush result kept", 64'(v1_result), 64'(14));
        n_ov = 0;
        repeat (40) begin
            @(negedge clk);
            if (v1_out_valid) n_ov++;
        end
        chk("flush no out_valid", 64'(n_ov), 64'(0));
        d1_run(2'b11, 32'd1000, 32'd3, 32'd1, 33, 0, "post-flush remu");

        // Flush with in_valid in IDLE: not accepted.
        v1_op = 2'b01; v1_a = 32'd9; v1_b = 32'd0; v1_in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        v1_in_valid = 1'b0; flush = 1'b0;
        chk("flush+valid in_ready", 64'(v1_in_ready), 64'(1));
        @(negedge clk);
        chk("flush+valid out_valid", 64'(v1_out_valid), 64'(0));

        // Reset in CALC cycle 10.
        v1_op = 2'b00; v1_a = 32'd1000; v1_b = 32'd7; v1_in_valid = 1'b1;
        @(negedge clk);
        v1_in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid rst in_ready", 64'(v1_in_ready), 64'(1));
        chk("mid rst result", 64'(v1_result), 64'(0));
        n_ov = 0;
        repeat (40) begin
            @(negedge clk);
            if (v1_out_valid) n_ov++;
        end
        chk("mid rst no out_valid", 64'(n_ov), 64'(0));
        d1_run(2'b00, 32'hFFFF_FC18, 32'd3, 32'hFFFF_FEB3, 33, 0, "post-rst div");

        // Random vectors, XLEN=32 BPC=1.
        for (int i = 0; i < 200; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra32 = $urandom; rb32 = $urandom;
            case ($urandom_range(0, 9))
                0: rb32 = 32'h0;
                1: begin ra32 = 32'h8000_0000; rb32 = 32'hFFFF_FFFF; end
                2: rb32 = 32'($urandom_range(1, 15));
                3: rb32 = rb32 >> $urandom_range(0, 31);
                default: ;
            endcase
            sp = (rb32 == 32'h0) || (!rop[0] && ra32 == 32'h8000_0000 && rb32 == 32'hFFFF_FFFF);
            d1_run(rop, ra32, rb32, ref32(rop, ra32, rb32), sp ? 1 : 33, 0, "d1 rnd");
        end

        // Random vectors, XLEN=64 BPC=2.
        for (int i = 0; i < 1000; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra64 = {$urandom, $urandom}; rb64 = {$urandom, $urandom};
            case ($urandom_range(0, 9))
                0: rb64 = 64'h0;
                1: begin ra64 = 64'h8000_0000_0000_0000; rb64 = 64'hFFFF_FFFF_FFFF_FFFF; end
                2: rb64 = 64'($urandom_range(1, 15));
                3: rb64 = rb64 >> $urandom_range(0, 63);
                4: ra64 = 64'hFFFF_FFFF_FFFF_FFFF;
                default: ;
            endcase
            sp = (rb64 == 64'h0) ||
                 (!rop[0] && ra64 == 64'h8000_0000_0000_0000 && rb64 == 64'hFFFF_FFFF_FFFF_FFFF);
            d2_run(rop, ra64, rb64, ref64(rop, ra64, rb64), sp ? 1 : 33, "d2 rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
